fc1_blocklock: RTL and testbench
================================

// Module: fc1_blocklock
// PURPOSE
//  64b/66b receive block-lock FSM in the FC1 RX path, one stage upstream of the FC1 interval-stats block.
//  Tests the sync header of each block from the RX gearbox and asks the gearbox to slip one bit when the
//  alignment is wrong. Reports lock status. Emits a one-cycle loss-of-block-lock pulse, which drives
//  CSR_EXPT_LOSS_BLOCKLOCK at the stats block.
// PARAMETERS
//  LOCK_CNT    64  consecutive valid headers required to declare lock; also the monitor window size in LOCKED
//  BAD_SH_MAX  16  invalid headers within one LOCKED window that cause loss of lock
//  SLIP_WAIT   32  valid-strobe cycles ignored after a slip so the gearbox can realign
// PORTS
//  iRX_CLK          in   1  RX recovered clock; the only clock
//  iRX_RST_N        in   1  synchronous reset, active-low
//  iSIGNAL_OK       in   1  PMA signal detect; low forces the unlocked state
//  iSH_VALID        in   1  iSH carries a new block header this cycle (gearbox strobe)
//  iSH              in   2  sync header of the current block
//  oBLOCK_LOCK      out  1  block lock achieved
//  oSLIP            out  1  one-cycle request to the gearbox: shift alignment by one bit
//  oLOSS_BLOCKLOCK  out  1  one-cycle pulse on each locked->unlocked transition
//  oSLIP_CNT        out  8  slips since reset; wraps
// BEHAVIOUR
//  - Valid header: iSH==2'b01 or 2'b10. Invalid header: 2'b00 or 2'b11. iSH is ignored when iSH_VALID=0.
//  - Reset (iRX_RST_N=0 at a clock edge):
//      * state=IDLE; all counters=0; all outputs=0.
//  - Counters:
//      * sh_cnt: $clog2(LOCK_CNT+1) bits. bad_cnt: $clog2(BAD_SH_MAX+1) bits. wait_cnt: $clog2(SLIP_WAIT+1) bits.
//      * Counters advance only on cycles with iSH_VALID=1.
//  - All outputs are registered: each one changes the cycle after the iSH sample that causes it.
//  - States:
//   IDLE: oBLOCK_LOCK=0; counters held at 0. Go to TEST when iSIGNAL_OK=1.
//   TEST: valid header -> sh_cnt++. Invalid header -> SLIP.
//         The sample that brings sh_cnt to LOCK_CNT -> LOCKED; set oBLOCK_LOCK=1; clear sh_cnt and bad_cnt.
//   LOCKED: every strobe -> sh_cnt++. Invalid header -> bad_cnt++.
//           bad_cnt reaches BAD_SH_MAX -> oBLOCK_LOCK=0; pulse oLOSS_BLOCKLOCK; go to SLIP.
//           sh_cnt reaches LOCK_CNT with bad_cnt<BAD_SH_MAX -> clear both counters; stay LOCKED.
//   SLIP: oSLIP=1 for exactly one cycle; oSLIP_CNT++ (wraps 255->0); clear wait_cnt. Go to SLIP_WAIT next cycle.
//   SLIP_WAIT: wait_cnt++ on each strobe; iSH ignored. wait_cnt reaches SLIP_WAIT -> clear sh_cnt; go to TEST.
//  - Boundary rules:
//      * iSIGNAL_OK=0 in any state -> IDLE next cycle with counters cleared.
//        If the block was LOCKED, oLOSS_BLOCKLOCK pulses once. A slip request is never issued that cycle.
//      * Same sample is both the BAD_SH_MAX-th invalid and the end of the window: loss of lock wins.
//      * A TEST invalid header on the sample that would reach LOCK_CNT: slip; no lock.
//      * iSH_VALID low for any number of cycles: state and counters hold.
//      * Reset mid-slip or mid-wait: same as any reset. No oSLIP or oLOSS_BLOCKLOCK pulse is emitted.
//      * oLOSS_BLOCKLOCK and oSLIP are never high in the same cycle. At most one loss pulse per lock episode.
// STRUCTURE
//  - Additions to fc1_pkg:
//      * typedef enum logic [2:0] {IDLE,TEST,LOCKED,SLIP,SLIP_WAIT} fc1_blocklock_state_e
//      * localparam logic [1:0] FC1_SH_DATA=2'b01, FC1_SH_CTRL=2'b10
//  - Single flat module with one FSM and its counters; no sub-module.
//  - oLOSS_BLOCKLOCK and oSLIP_CNT are in the iRX_CLK domain; the stats block consumes them without a synchronizer.
// TESTING
//  1. Reset, then iSIGNAL_OK=1 and 64 valid headers, strobe every cycle
//     -> oBLOCK_LOCK=1 one cycle after the 64th sample; oSLIP never asserted.
//  2. In TEST: 10 valid headers, then iSH=2'b11
//     -> oSLIP pulses 1 cycle; oSLIP_CNT=1; no TEST activity for 32 strobes; then 64 valid headers -> lock.
//  3. LOCKED: 15 invalid headers in one 64-block window, then a clean window
//     -> lock held, no loss pulse. Next window with 16 invalid headers
//     -> oLOSS_BLOCKLOCK one cycle; oBLOCK_LOCK=0; oSLIP next cycle.
//  4. LOCKED, 16th invalid header placed on the 64th sample of the window
//     -> loss of lock (priority); exactly one loss pulse.
//  5. LOCKED, drop iSIGNAL_OK
//     -> one loss pulse; state IDLE; no oSLIP. Repeat while in SLIP_WAIT
//     -> no loss pulse; IDLE.
//  6. 256 forced slips -> oSLIP_CNT wraps to 0.
//     Assert iRX_RST_N=0 mid-SLIP_WAIT with iSH_VALID toggling 50%
//     -> all outputs 0 next cycle, no pulses.

Source files
------------

// File: rtl/fc1_pkg.sv
// Shared FC1 receive-path types: block-lock FSM states and 64b/66b sync-header codes.
package fc1_pkg;

    typedef enum logic [2:0] {IDLE, TEST, LOCKED, SLIP, SLIP_WAIT} fc1_blocklock_state_e;

    localparam logic [1:0] FC1_SH_DATA = 2'b01;
    localparam logic [1:0] FC1_SH_CTRL = 2'b10;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == FC1_SH_DATA) || (sh == FC1_SH_CTRL);
    endfunction

endpackage

// File: rtl/fc1_blocklock.sv
// 64b/66b receive block-lock FSM: hunts for sync-header alignment, asks the gearbox to slip,
// and monitors lock quality in fixed windows of headers.
module fc1_blocklock
    import fc1_pkg::*;
#(
    parameter int LOCK_CNT   = 64,
    parameter int BAD_SH_MAX = 16,
    parameter int SLIP_WAIT  = 32
) (
    input  logic       iRX_CLK,
    input  logic       iRX_RST_N,
    input  logic       iSIGNAL_OK,
    input  logic       iSH_VALID,
    input  logic [1:0] iSH,
    output logic       oBLOCK_LOCK,
    output logic       oSLIP,
    output logic       oLOSS_BLOCKLOCK,
    output logic [7:0] oSLIP_CNT
);

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(BAD_SH_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    fc1_blocklock_state_e state;
    logic [SH_W-1:0]      sh_cnt;
    logic [BAD_W-1:0]     bad_cnt;
    logic [WAIT_W-1:0]    wait_cnt;

    logic                 hdr_ok;
    logic [SH_W-1:0]      sh_inc;
    logic [BAD_W-1:0]     bad_nxt;
    logic [WAIT_W-1:0]    wait_inc;

    assign hdr_ok   = sh_is_valid(iSH);
    assign sh_inc   = sh_cnt + SH_W'(1);
    assign bad_nxt  = bad_cnt + (hdr_ok ? BAD_W'(0) : BAD_W'(1));
    assign wait_inc = wait_cnt + WAIT_W'(1);

    always_ff @(posedge iRX_CLK) begin
        if (!iRX_RST_N) begin
            state           <= IDLE;
            sh_cnt          <= '0;
            bad_cnt         <= '0;
            wait_cnt        <= '0;
            oBLOCK_LOCK     <= 1'b0;
            oSLIP           <= 1'b0;
            oLOSS_BLOCKLOCK <= 1'b0;
            oSLIP_CNT       <= '0;
        end else begin
            oSLIP           <= 1'b0;
            oLOSS_BLOCKLOCK <= 1'b0;
            // Losing signal overrides everything, including a pending slip request.
            if (!iSIGNAL_OK) begin
                state           <= IDLE;
                sh_cnt          <= '0;
                bad_cnt         <= '0;
                wait_cnt        <= '0;
                oBLOCK_LOCK     <= 1'b0;
                oLOSS_BLOCKLOCK <= (state == LOCKED);
            end else begin
                case (state)
                    IDLE: begin
                        sh_cnt   <= '0;
                        bad_cnt  <= '0;
                        wait_cnt <= '0;
                        state    <= TEST;
                    end
                    TEST: begin
                        if (iSH_VALID) begin
                            if (!hdr_ok) begin
                                state <= SLIP;
                            end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                                state       <= LOCKED;
                                oBLOCK_LOCK <= 1'b1;
                                sh_cnt      <= '0;
                                bad_cnt     <= '0;
                            end else begin
                                sh_cnt <= sh_inc;
                            end
                        end
                    end
                    LOCKED: begin
                        // Loss of lock takes priority over a window rollover on the same header.
                        if (iSH_VALID) begin
                            if (bad_nxt == BAD_W'(BAD_SH_MAX)) begin
                                state           <= SLIP;
                                oBLOCK_LOCK     <= 1'b0;
                                oLOSS_BLOCKLOCK <= 1'b1;
                                sh_cnt          <= '0;
                                bad_cnt         <= '0;
                            end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                                sh_cnt  <= '0;
                                bad_cnt <= '0;
                            end else begin
                                sh_cnt  <= sh_inc;
                                bad_cnt <= bad_nxt;
                            end
                        end
                    end
                    SLIP: begin
                        oSLIP     <= 1'b1;
                        oSLIP_CNT <= oSLIP_CNT + 8'd1;
                        wait_cnt  <= '0;
                        state     <= fc1_pkg::SLIP_WAIT;
                    end
                    fc1_pkg::SLIP_WAIT: begin
                        if (iSH_VALID) begin
                            if (wait_inc == WAIT_W'(SLIP_WAIT)) begin
                                sh_cnt <= '0;
                                state  <= TEST;
                            end else begin
                                wait_cnt <= wait_inc;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fc1_blocklock.sv
// Randomized bench for fc1_blocklock against a countdown-style model of the lock rules.
module tb_fc1_blocklock;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig_ok = 1'b0;
    logic       sh_valid = 1'b0;
    logic [1:0] sh = 2'b00;
    logic       lock, slip, loss;
    logic [7:0] slip_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc1_blocklock dut (
        .iRX_CLK        (clk),
        .iRX_RST_N      (rst_n),
        .iSIGNAL_OK     (sig_ok),
        .iSH_VALID      (sh_valid),
        .iSH            (sh),
        .oBLOCK_LOCK    (lock),
        .oSLIP          (slip),
        .oLOSS_BLOCKLOCK(loss),
        .oSLIP_CNT      (slip_cnt)
    );

    // Reference model: phases with countdowns of headers still needed.
    localparam int PH_DOWN = 0, PH_HUNT = 1, PH_LOCK = 2, PH_SLIPREQ = 3, PH_WAIT = 4;
    int         ph = PH_DOWN;
    int         need_left, win_left, bad_seen, wait_left;
    logic       e_lock = 1'b0, e_slip = 1'b0, e_loss = 1'b0;
    logic [7:0] e_cnt = 8'd0;
    int         slip_seen, loss_seen;

    function automatic logic [10:0] dut_vec();
        return {lock, slip, loss, slip_cnt};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {e_lock, e_slip, e_loss, e_cnt};
    endfunction

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic v, input logic [1:0] h);
        bit is_bad;
        is_bad = (h == 2'b00) || (h == 2'b11);
        e_slip = 1'b0;
        e_loss = 1'b0;
        if (!r) begin
            ph = PH_DOWN; e_lock = 1'b0; e_cnt = 8'd0;
        end else if (!s) begin
            e_loss = (ph == PH_LOCK);
            e_lock = 1'b0;
            ph = PH_DOWN;
        end else begin
            case (ph)
                PH_DOWN: begin ph = PH_HUNT; need_left = 64; end
                PH_HUNT: if (v) begin
                    if (is_bad) ph = PH_SLIPREQ;
                    else begin
                        need_left--;
                        if (need_left == 0) begin
                            ph = PH_LOCK; e_lock = 1'b1; win_left = 64; bad_seen = 0;
                        end
                    end
                end
                PH_LOCK: if (v) begin
                    win_left--;
                    if (is_bad) bad_seen++;
                    if (bad_seen == 16) begin
                        e_lock = 1'b0; e_loss = 1'b1; ph = PH_SLIPREQ;
                    end else if (win_left == 0) begin
                        win_left = 64; bad_seen = 0;
                    end
                end
                PH_SLIPREQ: begin
                    e_slip = 1'b1; e_cnt = e_cnt + 8'd1; ph = PH_WAIT; wait_left = 32;
                end
                default: if (v) begin
                    wait_left--;
                    if (wait_left == 0) begin ph = PH_HUNT; need_left = 64; end
                end
            endcase
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic v, input logic [1:0] h);
        @(negedge clk);
        rst_n = r; sig_ok = s; sh_valid = v; sh = h;
        @(posedge clk);
        model_step(r, s, v, h);
        #1;
        if (slip) slip_seen++;
        if (loss) loss_seen++;
    endtask

    task automatic bring_up();
        tick(1'b0, 1'b0, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 64; i++) tick(1'b1, 1'b1, 1'b1, good_hdr());
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            checks++;
            if (dut_vec() !== 11'd0) begin
                errors++;
                $display("FAIL reset got=%h exp=%h", dut_vec(), 11'd0);
            end
        end
    endtask

    task automatic test_lock();
        tick(1'b0, 1'b0, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        slip_seen = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, 1'b1, 1'b1, good_hdr());
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lock_seq i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (lock !== 1'b1 || slip_seen != 0) begin
            errors++;
            $display("FAIL lock_final lock=%b slips=%0d exp lock=1 slips=0", lock, slip_seen);
        end
    endtask

    task automatic test_slip();
        int n;
        tick(1'b0, 1'b0, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b1, good_hdr());
        tick(1'b1, 1'b1, 1'b1, 2'b11);
        n = 0;
        while (!e_lock && n < 600) begin
            tick(1'b1, 1'b1, 1'($urandom_range(0, 3) != 0), good_hdr());
            n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL slip_seq n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (lock !== 1'b1 || slip_cnt !== 8'd1) begin
            errors++;
            $display("FAIL slip_relock lock=%b cnt=%0d exp lock=1 cnt=1", lock, slip_cnt);
        end
    endtask

    // One 64-header window with invalid headers at the marked positions and random idle gaps.
    task automatic run_window(input string name, input bit pos[64]);
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 4) == 0) tick(1'b1, 1'b1, 1'b0, bad_hdr());
            tick(1'b1, 1'b1, 1'b1, pos[i] ? bad_hdr() : good_hdr());
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s i=%0d got=%h exp=%h", name, i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_window();
        bit pos[64];
        int n, p;
        bring_up();
        loss_seen = 0;
        pos = '{default: 1'b0};
        n = 0;
        while (n < 15) begin
            p = $urandom_range(0, 63);
            if (!pos[p]) begin pos[p] = 1'b1; n++; end
        end
        run_window("win15", pos);
        pos = '{default: 1'b0};
        run_window("win_clean", pos);
        checks++;
        if (lock !== 1'b1 || loss_seen != 0) begin
            errors++;
            $display("FAIL win_hold lock=%b losses=%0d exp lock=1 losses=0", lock, loss_seen);
        end
        n = 0;
        while (n < 16) begin
            p = $urandom_range(0, 63);
            if (!pos[p]) begin pos[p] = 1'b1; n++; end
        end
        slip_seen = 0;
        run_window("win16", pos);
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        checks++;
        if (lock !== 1'b0 || loss_seen != 1 || slip_seen != 1) begin
            errors++;
            $display("FAIL win_loss lock=%b losses=%0d slips=%0d exp 0/1/1", lock, loss_seen, slip_seen);
        end
    endtask

    task automatic test_priority();
        bit pos[64];
        int n, p;
        bring_up();
        pos = '{default: 1'b0};
        pos[63] = 1'b1;
        n = 0;
        while (n < 15) begin
            p = $urandom_range(0, 62);
            if (!pos[p]) begin pos[p] = 1'b1; n++; end
        end
        loss_seen = 0;
        run_window("prio", pos);
        checks++;
        if (loss !== 1'b1 || lock !== 1'b0 || slip !== 1'b0) begin
            errors++;
            $display("FAIL prio_edge loss=%b lock=%b slip=%b exp 1/0/0", loss, lock, slip);
        end
        tick(1'b1, 1'b1, 1'b1, good_hdr());
        tick(1'b1, 1'b1, 1'b1, good_hdr());
        checks++;
        if (loss_seen != 1) begin
            errors++;
            $display("FAIL prio_count losses=%0d exp=1", loss_seen);
        end
    endtask

    task automatic test_signal_drop();
        bring_up();
        loss_seen = 0; slip_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), bad_hdr());
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop_locked i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (loss_seen != 1 || slip_seen != 0 || lock !== 1'b0) begin
            errors++;
            $display("FAIL drop_locked_sum losses=%0d slips=%0d lock=%b exp 1/0/0", loss_seen, slip_seen, lock);
        end
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b1, good_hdr());
        tick(1'b1, 1'b1, 1'b1, 2'b00);
        tick(1'b1, 1'b1, 1'b1, good_hdr());
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, bad_hdr());
        loss_seen = 0; slip_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, i != 0, 1'b1, good_hdr());
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop_wait i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (loss_seen != 0 || slip_seen != 0) begin
            errors++;
            $display("FAIL drop_wait_sum losses=%0d slips=%0d exp 0/0", loss_seen, slip_seen);
        end
    endtask

    task automatic test_slip_wrap();
        int n;
        tick(1'b0, 1'b0, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 1'b0, 2'b00);
        slip_seen = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1'b1, 1'b1, 1'b1, bad_hdr());
            n = 0;
            while (ph != PH_HUNT && n < 120) begin
                tick(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                n++;
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL wrap k=%0d n=%0d got=%h exp=%h", k, n, dut_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (slip_cnt !== 8'd0 || slip_seen != 256) begin
            errors++;
            $display("FAIL wrap_cnt cnt=%0d slips=%0d exp cnt=0 slips=256", slip_cnt, slip_seen);
        end
        tick(1'b1, 1'b1, 1'b1, bad_hdr());
        tick(1'b1, 1'b1, 1'b1, good_hdr());
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)), good_hdr());
        slip_seen = 0; loss_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            checks++;
            if (dut_vec() !== 11'd0) begin
                errors++;
                $display("FAIL reset_wait i=%0d got=%h exp=%h", i, dut_vec(), 11'd0);
            end
        end
        checks++;
        if (slip_seen != 0 || loss_seen != 0) begin
            errors++;
            $display("FAIL reset_wait_pulses slips=%0d losses=%0d exp 0/0", slip_seen, loss_seen);
        end
    endtask

    task automatic test_random();
        int bad_pct;
        logic r, s;
        tick(1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) bad_pct = ($urandom_range(0, 1) == 0) ? 1 : 30;
            r = ($urandom_range(0, 999) != 0);
            s = ($urandom_range(0, 299) != 0);
            tick(r, s, 1'($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) < bad_pct) ? bad_hdr() : good_hdr());
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            checks++;
            if (slip && loss) begin
                errors++;
                $display("FAIL random_excl i=%0d slip=%b loss=%b exp not both", i, slip, loss);
            end
        end
    endtask

    initial begin
        slip_seen = 0;
        loss_seen = 0;
        test_reset();
        test_lock();
        test_slip();
        test_window();
        test_priority();
        test_signal_drop();
        test_slip_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
